// File: rtl/dot_product_block.sv
// Unary dot-product engine: captures w/x vectors, emits one out pulse per unit of
// each channel product in channel order, then strobes done with the accumulated sum.
module dot_product_block #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 1,
    parameter int SUM_W    = 2*WIDTH + $clog2(CHANNELS+1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_rdy,
    input  logic [CHANNELS*WIDTH-1:0] w,
    input  logic [CHANNELS*WIDTH-1:0] x,
    output logic                      busy,
    output logic                      out,
    output logic                      done,
    output logic [SUM_W-1:0]          sum
);

    localparam int PW = 2*WIDTH;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    logic [CHANNELS*WIDTH-1:0] w_q;
    logic [CHANNELS*WIDTH-1:0] x_q;
    logic [CW-1:0]             ch;
    logic [PW-1:0]             cnt;
    logic [SUM_W-1:0]          acc;

    logic [PW-1:0]             p_first;
    logic [PW-1:0]             p_next;
    logic [SUM_W-1:0]          acc_next;
    logic                      ch_last;

    // Full-width product of one channel, never truncated.
    function automatic logic [PW-1:0] prod(input logic [CHANNELS*WIDTH-1:0] wv,
                                           input logic [CHANNELS*WIDTH-1:0] xv,
                                           input int idx);
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        a = PW'(wv[idx*WIDTH +: WIDTH]);
        b = PW'(xv[idx*WIDTH +: WIDTH]);
        return a * b;
    endfunction

    always_comb begin
        p_first  = prod(w, x, 0);
        ch_last  = (ch == CW'(CHANNELS-1));
        p_next   = ch_last ? '0 : prod(w_q, x_q, int'(ch) + 1);
        acc_next = acc + SUM_W'(out);
    end

    // cnt holds the pulses still owed by the current channel, including the
    // cycle in progress; 0 and 1 both mean this cycle is the channel's last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            w_q   <= '0;
            x_q   <= '0;
            ch    <= '0;
            cnt   <= '0;
            acc   <= '0;
            sum   <= '0;
            busy  <= 1'b0;
            out   <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out  <= 1'b0;
                    done <= 1'b0;
                    if (in_rdy) begin
                        w_q   <= w;
                        x_q   <= x;
                        ch    <= '0;
                        cnt   <= p_first;
                        out   <= (p_first != '0);
                        acc   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt > PW'(1)) begin
                        cnt <= cnt - PW'(1);
                        out <= 1'b1;
                    end else if (ch_last) begin
                        cnt   <= '0;
                        out   <= 1'b0;
                        done  <= 1'b1;
                        sum   <= acc_next;
                        state <= DONE;
                    end else begin
                        ch  <= ch + CW'(1);
                        cnt <= p_next;
                        out <= (p_next != '0);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    out   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_block.sv
// Bench for dot_product_block: a single-channel and a four-channel instance
// share clock and reset; results are compared against a plain-arithmetic model.
module tb_dot_product_block;

    logic        clk;
    logic        reset;
    logic        rdy_a, rdy_b;
    logic [3:0]  w_a, x_a;
    logic [15:0] w_b, x_b;
    logic        busy_a, out_a, done_a;
    logic        busy_b, out_b, done_b;
    logic [8:0]  sum_a;
    logic [10:0] sum_b;

    logic        sel;
    logic        obs_busy, obs_out, obs_done;
    logic [10:0] obs_sum;

    int n_assert;
    int n_fail;

    dot_product_block #(.WIDTH(4), .CHANNELS(1)) dut_a (
        .clk(clk), .reset(reset), .in_rdy(rdy_a), .w(w_a), .x(x_a),
        .busy(busy_a), .out(out_a), .done(done_a), .sum(sum_a)
    );

    dot_product_block #(.WIDTH(4), .CHANNELS(4)) dut_b (
        .clk(clk), .reset(reset), .in_rdy(rdy_b), .w(w_b), .x(x_b),
        .busy(busy_b), .out(out_b), .done(done_b), .sum(sum_b)
    );

    assign obs_busy = sel ? busy_b : busy_a;
    assign obs_out  = sel ? out_b  : out_a;
    assign obs_done = sel ? done_b : done_a;
    assign obs_sum  = sel ? sum_b  : {2'b00, sum_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation on the selected instance; the model is the dot product and
    // the RUN length sum(max(p,1)). With poke, a second request arrives mid-RUN.
    task automatic run_op(input logic s, input logic [15:0] wv, input logic [15:0] xv,
                          input bit poke);
        int exp_sum, exp_len, p, pulses, done_k, busy_low, nch;
        nch = s ? 4 : 1;
        exp_sum = 0;
        exp_len = 0;
        for (int i = 0; i < nch; i++) begin
            p = int'(wv[i*4 +: 4]) * int'(xv[i*4 +: 4]);
            exp_sum += p;
            exp_len += (p > 0) ? p : 1;
        end
        sel = s;
        if (s) begin
            w_b = wv; x_b = xv; rdy_b = 1'b1;
        end else begin
            w_a = wv[3:0]; x_a = xv[3:0]; rdy_a = 1'b1;
        end
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        w_a = 4'($urandom);
        x_a = 4'($urandom);
        w_b = 16'($urandom);
        x_b = 16'($urandom);
        pulses = 0;
        done_k = 0;
        busy_low = 0;
        for (int k = 1; k <= 1200 && done_k == 0; k++) begin
            @(negedge clk);
            if (poke && k == 3) begin
                w_a = 4'd15; x_a = 4'd15; rdy_a = 1'b1;
            end
            if (poke && k == 4) rdy_a = 1'b0;
            if (obs_done) begin
                done_k = k;
                check("done_sum", 32'(obs_sum), exp_sum);
                check("done_out", 32'(obs_out), 0);
                check("done_busy", 32'(obs_busy), 1);
            end else begin
                if (obs_out) pulses++;
                if (!obs_busy) busy_low++;
            end
        end
        rdy_a = 1'b0;
        check("done_cycle", done_k, exp_len + 1);
        check("pulse_count", pulses, exp_sum);
        check("busy_in_run", busy_low, 0);
        @(negedge clk);
        check("idle_done", 32'(obs_done), 0);
        check("idle_busy", 32'(obs_busy), 0);
        check("idle_out", 32'(obs_out), 0);
        check("idle_sum_hold", 32'(obs_sum), exp_sum);
    endtask

    initial begin
        int highs, strobes;
        logic [15:0] rw, rx;
        n_assert = 0;
        n_fail = 0;
        sel = 1'b0;
        reset = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0;
        w_a = '0; x_a = '0; w_b = '0; x_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_out_a", 32'(out_a), 0);
        check("rst_done_a", 32'(done_a), 0);
        check("rst_sum_a", 32'(sum_a), 0);
        check("rst_busy_b", 32'(busy_b), 0);
        check("rst_sum_b", 32'(sum_b), 0);
        reset = 1'b0;

        // First capture on the first edge after reset release.
        run_op(1'b0, 16'd2, 16'd3, 1'b0);
        // Zero channel then a 15-pulse channel, trailing zero channels.
        run_op(1'b1, 16'h0032, 16'h0050, 1'b0);
        // Largest possible result, 900 contiguous pulses.
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        // Request during RUN with different operands must be ignored.
        run_op(1'b0, 16'd3, 16'd5, 1'b1);

        // Abort mid-RUN with an asynchronous reset.
        sel = 1'b0;
        w_a = 4'd3; x_a = 4'd5; rdy_a = 1'b1;
        @(posedge clk);
        #1 rdy_a = 1'b0;
        highs = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_a) highs++;
        end
        check("pre_abort_pulses", highs, 4);
        #2 reset = 1'b1;
        #1;
        check("abort_out", 32'(out_a), 0);
        check("abort_busy", 32'(busy_a), 0);
        check("abort_done", 32'(done_a), 0);
        check("abort_sum", 32'(sum_a), 0);
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a || out_a) strobes++;
        end
        check("abort_quiet", strobes, 0);
        reset = 1'b0;
        run_op(1'b0, 16'd1, 16'd1, 1'b0);

        // Exhaustive single-channel sweep.
        for (int wi = 0; wi < 16; wi++)
            for (int xi = 0; xi < 16; xi++)
                run_op(1'b0, 16'(wi), 16'(xi), 1'b0);

        // Random four-channel operations, some channels forced to zero.
        for (int n = 0; n < 20; n++) begin
            rw = 16'($urandom);
            rx = 16'($urandom);
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 3) == 0) rx[c*4 +: 4] = 4'd0;
            run_op(1'b1, rw, rx, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_block.md
DOT_PRODUCT_BLOCK -- requirements
Module: dot_product_block

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, unsigned, WIDTH >= 1.
REQ-002 Parameter CHANNELS, default 1: number of w/x operand pairs, CHANNELS >= 1.
REQ-003 Parameter SUM_W, default 2*WIDTH+$clog2(CHANNELS+1): width of the accumulated result.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-high.
REQ-006 in_rdy  input  1  request to start an operation with the current w/x values.
REQ-007 w  input  CHANNELS*WIDTH  packed weights; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 x  input  CHANNELS*WIDTH  packed inputs, same packing as w.
REQ-009 busy  output  1  high while an operation is in progress, RUN and DONE states.
REQ-010 out  output  1  unary pulse stream: one high cycle per unit of product.
REQ-011 done  output  1  single-cycle completion strobe.
REQ-012 sum  output  SUM_W  dot product sum(w[i]*x[i]) of the last completed operation.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE, in_rdy high at a rising edge (the capture edge, T0) SHALL register all w and x values and channel index 0, and enter RUN.
REQ-015 in_rdy SHALL be ignored in RUN and DONE; captured operands SHALL NOT change during an operation.
REQ-016 In RUN, channel ch SHALL own a down-counter loaded with p = w[ch]*x[ch], computed at full 2*WIDTH width with no truncation.
REQ-017 Each RUN cycle with counter > 0 SHALL drive out=1, decrement the counter, and increment the running accumulator by 1.
REQ-018 A channel with p = 0 SHALL consume exactly one RUN cycle with out=0 and no accumulator change.
REQ-019 In the cycle a channel's count is exhausted (last pulse, or the single zero cycle), the next channel's product SHALL load with no gap cycle.
REQ-020 RUN SHALL last exactly sum over i of max(p_i, 1) cycles, starting at T0+1.
REQ-021 After the last channel's final RUN cycle, the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-022 In DONE, done=1 and out=0; sum SHALL equal the final accumulator value.
REQ-023 sum SHALL hold that value until the next capture edge, and SHALL be cleared to 0 at the next capture edge.
REQ-024 busy SHALL be high from T0+1 through the DONE cycle inclusive, and low in IDLE.
REQ-025 In IDLE, in_rdy is sampled again in the cycle after DONE; back-to-back operations therefore have a minimum spacing of RUN length + 2 cycles.
REQ-026 SUM_W SHALL be wide enough that CHANNELS*(2^WIDTH-1)^2 never wraps; the accumulator SHALL NOT saturate or wrap.
REQ-027 out, done and busy SHALL be registered outputs with no combinational path from in_rdy, w or x.

Reset
REQ-028 While reset is high, the FSM SHALL be in IDLE and busy=0, out=0, done=0, sum=0, with all counters, channel index and operand registers at 0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort immediately and asynchronously: no further out pulses and no done strobe.
REQ-030 The first capture SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-031 WIDTH=4, CHANNELS=1; w=2, x=3 -> out high T0+1..T0+6, done at T0+7, sum=6, busy low at T0+8.
REQ-032 CHANNELS=2; w={3,2}, x={5,0} (ch0: 2*0, ch1: 3*5) -> one zero cycle at T0+1, 15 pulses T0+2..T0+16, done at T0+17, sum=15.
REQ-033 CHANNELS=4, WIDTH=4; all w=x=15 -> 900 contiguous out pulses, done at T0+901, sum=900, no wrap.
REQ-034 Capture w=3, x=5 and pulse in_rdy again during RUN with different operands -> second request ignored, exactly 15 pulses, sum=15.
REQ-035 Reset asserted after 4 pulses of w=3, x=5 -> out, busy, done and sum go to 0 immediately, no done strobe; a new capture w=1, x=1 afterwards yields sum=1.
REQ-036 All products w,x in 0..15 swept with CHANNELS=1 -> pulse count equals sum equals w*x; RUN length equals max(w*x, 1).
